// File: rtl/simd_exec_pipe.sv
`default_nettype none
// ============================================================================
// Module      : simd_exec_pipe
// Description : Two-stage SIMD pixel execution pipe. S1 registers the operand
//               set; S2 registers the per-lane result and the saturation flag.
//               Valid/ready handshakes on both sides, no bubbles at full rate.
// Revision    : 1.0 - initial release
// ============================================================================
module simd_exec_pipe #(
    parameter int LANES   = 8,
    parameter int PIXEL_W = 8,
    parameter int OP_W    = 4,
    parameter int AW      = LANES * PIXEL_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] opCode,
    input  logic [AW-1:0]   arrayA,
    input  logic [AW-1:0]   arrayB,
    input  logic [LANES-1:0] laneMask,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   executionResult,
    output logic            satFlag,
    output logic [15:0]     txnCount
);

    localparam logic [OP_W-1:0] c_opAdd    = OP_W'(0);
    localparam logic [OP_W-1:0] c_opSub    = OP_W'(1);
    localparam logic [OP_W-1:0] c_opAddSat = OP_W'(2);
    localparam logic [OP_W-1:0] c_opSubSat = OP_W'(3);
    localparam logic [OP_W-1:0] c_opAnd    = OP_W'(4);
    localparam logic [OP_W-1:0] c_opOr     = OP_W'(5);
    localparam logic [OP_W-1:0] c_opXor    = OP_W'(6);
    localparam logic [OP_W-1:0] c_opNot    = OP_W'(7);
    localparam logic [OP_W-1:0] c_opShl    = OP_W'(8);
    localparam logic [OP_W-1:0] c_opShr    = OP_W'(9);
    localparam logic [OP_W-1:0] c_opMin    = OP_W'(10);
    localparam logic [OP_W-1:0] c_opMax    = OP_W'(11);
    localparam logic [OP_W-1:0] c_opAvg    = OP_W'(12);
    localparam logic [OP_W-1:0] c_opAbsDif = OP_W'(13);
    localparam logic [OP_W-1:0] c_opPassA  = OP_W'(14);
    localparam logic [OP_W-1:0] c_opPassB  = OP_W'(15);

    logic              r_s1Valid;
    logic [OP_W-1:0]   r_s1Op;
    logic [AW-1:0]     r_s1A;
    logic [AW-1:0]     r_s1B;
    logic [LANES-1:0]  r_s1Mask;
    logic              r_s2Valid;
    logic [AW-1:0]     r_s2Result;
    logic              r_s2Sat;
    logic [15:0]       r_txnCount;

    logic              w_s2Load;
    logic              w_accept;
    logic [AW-1:0]     w_laneRes;
    logic [LANES-1:0]  w_laneSat;

    // S2 takes S1 when it is empty or emptying on this same edge
    assign w_s2Load = r_s1Valid && (!r_s2Valid || out_ready);
    assign in_ready = !r_s1Valid || w_s2Load;
    assign w_accept = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [PIXEL_W-1:0] w_a;
            logic [PIXEL_W-1:0] w_b;
            logic [PIXEL_W-1:0] w_res;
            logic               w_sat;
            logic [PIXEL_W:0]   w_sum;
            logic [PIXEL_W:0]   w_diff;
            logic [PIXEL_W:0]   w_avg;
            logic [31:0]        w_shAmt;

            assign w_a = r_s1A[gi*PIXEL_W +: PIXEL_W];
            assign w_b = r_s1B[gi*PIXEL_W +: PIXEL_W];

            // Lane ALU; the extra MSB of sum/diff is the carry/borrow used for clamping
            always_comb begin
                w_sum   = {1'b0, w_a} + {1'b0, w_b};
                w_diff  = {1'b0, w_a} - {1'b0, w_b};
                w_avg   = w_sum + {{PIXEL_W{1'b0}}, 1'b1};
                w_shAmt = 32'(w_b) % 32'(PIXEL_W);
                w_res   = '0;
                w_sat   = 1'b0;
                case (r_s1Op)
                    c_opAdd:    w_res = w_sum[PIXEL_W-1:0];
                    c_opSub:    w_res = w_diff[PIXEL_W-1:0];
                    c_opAddSat: begin
                        w_res = w_sum[PIXEL_W] ? '1 : w_sum[PIXEL_W-1:0];
                        w_sat = w_sum[PIXEL_W];
                    end
                    c_opSubSat: begin
                        w_res = w_diff[PIXEL_W] ? '0 : w_diff[PIXEL_W-1:0];
                        w_sat = w_diff[PIXEL_W];
                    end
                    c_opAnd:    w_res = w_a & w_b;
                    c_opOr:     w_res = w_a | w_b;
                    c_opXor:    w_res = w_a ^ w_b;
                    c_opNot:    w_res = ~w_a;
                    c_opShl:    w_res = w_a << w_shAmt;
                    c_opShr:    w_res = w_a >> w_shAmt;
                    c_opMin:    w_res = (w_a < w_b) ? w_a : w_b;
                    c_opMax:    w_res = (w_a > w_b) ? w_a : w_b;
                    c_opAvg:    w_res = w_avg[PIXEL_W:1];
                    c_opAbsDif: w_res = w_diff[PIXEL_W] ? (w_b - w_a) : w_diff[PIXEL_W-1:0];
                    c_opPassA:  w_res = w_a;
                    c_opPassB:  w_res = w_b;
                    default:    w_res = '0;
                endcase
                // Disabled lanes pass A through and never report saturation
                if (!r_s1Mask[gi]) begin
                    w_res = w_a;
                    w_sat = 1'b0;
                end
            end

            assign w_laneRes[gi*PIXEL_W +: PIXEL_W] = w_res;
            assign w_laneSat[gi] = w_sat;
        end
    endgenerate

    // Stage 1: capture the accepted operand set, drop valid once it moves on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Op    <= '0;
            r_s1A     <= '0;
            r_s1B     <= '0;
            r_s1Mask  <= '0;
        end else if (w_accept) begin
            r_s1Valid <= 1'b1;
            r_s1Op    <= opCode;
            r_s1A     <= arrayA;
            r_s1B     <= arrayB;
            r_s1Mask  <= laneMask;
        end else if (w_s2Load) begin
            r_s1Valid <= 1'b0;
        end
    end

    // Stage 2: hold the result until consumed, replace it on a same-edge transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2Valid  <= 1'b0;
            r_s2Result <= '0;
            r_s2Sat    <= 1'b0;
        end else if (w_s2Load) begin
            r_s2Valid  <= 1'b1;
            r_s2Result <= w_laneRes;
            r_s2Sat    <= |w_laneSat;
        end else if (out_ready) begin
            r_s2Valid  <= 1'b0;
        end
    end

    // Count completed output handshakes, wrapping at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txnCount <= '0;
        end else if (r_s2Valid && out_ready) begin
            r_txnCount <= r_txnCount + 16'd1;
        end
    end

    assign out_valid       = r_s2Valid;
    assign executionResult = r_s2Result;
    assign satFlag         = r_s2Sat;
    assign txnCount        = r_txnCount;

endmodule
`default_nettype wire

// File: tb/tb_simd_exec_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_simd_exec_pipe
// Description : Scoreboard bench for simd_exec_pipe with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_exec_pipe;

    localparam int LANES   = 8;
    localparam int PIXEL_W = 8;
    localparam int OP_W    = 4;
    localparam int AW      = LANES * PIXEL_W;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  opCode;
    logic [AW-1:0]    arrayA;
    logic [AW-1:0]    arrayB;
    logic [LANES-1:0] laneMask;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    executionResult;
    logic             satFlag;
    logic [15:0]      txnCount;

    typedef struct packed {
        logic [AW-1:0] res;
        logic          sat;
    } exp_t;

    exp_t sb[$];
    int   total   = 0;
    int   bad     = 0;
    int   hsCount = 0;
    int   accCnt  = 0;
    int   runLen  = 0;
    int   maxRun  = 0;

    simd_exec_pipe #(.LANES(LANES), .PIXEL_W(PIXEL_W), .OP_W(OP_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .opCode          (opCode),
        .arrayA          (arrayA),
        .arrayB          (arrayB),
        .laneMask        (laneMask),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .executionResult (executionResult),
        .satFlag         (satFlag),
        .txnCount        (txnCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops and compares on every pending output handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                runLen++;
                if (runLen > maxRun) maxRun = runLen;
            end else begin
                runLen = 0;
            end
            check("txnCount", AW'(txnCount), AW'(hsCount[15:0]));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", AW'(out_valid), AW'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", executionResult, e.res);
                    check("satFlag", AW'(satFlag), AW'(e.sat));
                end
                hsCount++;
            end
        end
    end

    task automatic send(input logic [OP_W-1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [LANES-1:0] m, input logic [AW-1:0] er, input logic es,
                        output int stalls);
        logic acc;
        logic done;
        in_valid = 1'b1; opCode = op; arrayA = a; arrayB = b; laneMask = m;
        stalls = 0;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sb.push_back('{res: er, sat: es});
                accCnt++;
                done = 1'b1;
            end else begin
                stalls++;
            end
        end
        if (!done) check("send_timeout", AW'(0), AW'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk);
        check("drain_empty", AW'(sb.size()), AW'(0));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        hsCount = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        runLen = 0;
        maxRun = 0;
    endtask

    int st;
    int stallSum;

    initial begin
        in_valid = 1'b0; opCode = '0; arrayA = '0; arrayB = '0; laneMask = '0;
        out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", AW'(out_valid), AW'(0));
        check("rst_result", executionResult, '0);
        check("rst_txn", AW'(txnCount), AW'(0));
        do_reset();
        check("rst_in_ready", AW'(in_ready), AW'(1));

        // Saturating add, all lanes clamp; also latency of two edges
        send(4'd2, rep(8'hF0), rep(8'h20), 8'hFF, rep(8'hFF), 1'b1, st);
        check("lat_not_yet", AW'(out_valid), AW'(0));
        @(posedge clk); #1;
        check("lat_valid", AW'(out_valid), AW'(1));
        drain();

        send(4'd0, rep(8'hF0), rep(8'h20), 8'h0F, 64'hF0F0F0F0_10101010, 1'b0, st);
        send(4'd8, rep(8'h81), rep(8'h09), 8'hFF, rep(8'h02), 1'b0, st);
        send(4'd13, rep(8'h10), rep(8'h30), 8'hFF, rep(8'h20), 1'b0, st);
        send(4'd3, rep(8'h20), rep(8'hF0), 8'h01, 64'h20202020_20202000, 1'b1, st);
        send(4'd3, rep(8'h20), rep(8'hF0), 8'h00, rep(8'h20), 1'b0, st);
        send(4'd2, rep(8'h10), rep(8'h20), 8'hFF, rep(8'h30), 1'b0, st);
        send(4'd1, rep(8'h10), rep(8'h20), 8'hFF, rep(8'hF0), 1'b0, st);
        send(4'd9, rep(8'h80), rep(8'h0A), 8'hFF, rep(8'h20), 1'b0, st);
        send(4'd10, rep(8'h30), rep(8'h20), 8'hFF, rep(8'h20), 1'b0, st);
        send(4'd11, rep(8'h30), rep(8'h20), 8'hFF, rep(8'h30), 1'b0, st);
        send(4'd14, rep(8'h5A), rep(8'hA5), 8'hFF, rep(8'h5A), 1'b0, st);
        send(4'd15, rep(8'h5A), rep(8'hA5), 8'hFF, rep(8'hA5), 1'b0, st);
        drain();

        // Ten back-to-back averages from a fresh reset
        do_reset();
        stallSum = 0;
        for (int k = 0; k < 10; k++) begin
            send(4'd12, 64'h07060504_03020100, rep(8'h03), 8'hFF, 64'h05050404_03030202, 1'b0, st);
            stallSum += st;
        end
        drain();
        check("b2b_stalls", AW'(stallSum), AW'(0));
        check("b2b_run", AW'(maxRun), AW'(10));
        check("b2b_txn", AW'(txnCount), AW'(10));

        // Backpressure: four sets offered while the consumer stalls
        out_ready = 1'b0;
        accCnt = 0;
        fork
            begin
                send(4'd4, rep(8'hFF), rep(8'h0F), 8'hFF, rep(8'h0F), 1'b0, st);
                send(4'd5, rep(8'hF0), rep(8'h05), 8'hFF, rep(8'hF5), 1'b0, st);
                send(4'd6, rep(8'hFF), rep(8'h0F), 8'hFF, rep(8'hF0), 1'b0, st);
                send(4'd7, rep(8'h3C), rep(8'h00), 8'hFF, rep(8'hC3), 1'b0, st);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check("bp_accepted", AW'(accCnt), AW'(2));
                check("bp_in_ready", AW'(in_ready), AW'(0));
                check("bp_hold_valid", AW'(out_valid), AW'(1));
                check("bp_hold_result", executionResult, rep(8'h0F));
                @(posedge clk); #1;
                check("bp_hold_result2", executionResult, rep(8'h0F));
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two sets in flight
        out_ready = 1'b0;
        send(4'd14, rep(8'h11), rep(8'h00), 8'hFF, rep(8'h11), 1'b0, st);
        send(4'd14, rep(8'h22), rep(8'h00), 8'hFF, rep(8'h22), 1'b0, st);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        hsCount = 0;
        check("mid_rst_valid", AW'(out_valid), AW'(0));
        check("mid_rst_txn", AW'(txnCount), AW'(0));
        check("mid_rst_result", executionResult, '0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", AW'(in_ready), AW'(1));
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_no_stale", AW'(out_valid), AW'(0));
        check("post_rst_txn", AW'(txnCount), AW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
